// File: rtl/ika9958_vram_slot_sched.sv
// VRAM access-slot scheduler: shares non-display 8-cycle slots between refresh, CPU and command
// engine, and sequences RAS/CAS/WE/row-col mux. Optional IKA9958_VRAM_SCHED_STATS_EN adds stat_contend.
module ika9958_vram_slot_sched #(
    parameter int unsigned REFRESH_SLOTS = 16,
    parameter int unsigned CPU_MAXBURST  = 3
) (
    input  logic        phiA,
    input  logic        RST_async,
    input  logic        phiL_NCEN,
    input  logic [7:0]  m8c,
    input  logic        disp_own,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic        cmd_req,
    input  logic        cmd_wr,
    output logic [2:0]  grant,
    output logic        cpu_ack,
    output logic        cmd_ack,
    output logic        rd_stb,
    output logic        ras_n,
    output logic        cas_n,
    output logic        we_n,
    output logic        col_sel,
    output logic        proto_err,
    output logic [15:0] stat_contend
);

    localparam int unsigned TW = (REFRESH_SLOTS > 1) ? $clog2(REFRESH_SLOTS) : 1;
    localparam int unsigned SW = $clog2(CPU_MAXBURST + 1);

    typedef enum logic [1:0] {StIdle, StRow, StCol, StData} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      debt_q, debt_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic            wr_q, wr_d;
    logic [2:0]      grant_q, grant_d;
    logic            cpu_ack_q, cpu_ack_d;
    logic            cmd_ack_q, cmd_ack_d;
    logic            rd_stb_q, rd_stb_d;
    logic            ras_n_q, ras_n_d;
    logic            cas_n_q, cas_n_d;
    logic            we_n_q, we_n_d;
    logic            col_sel_q, col_sel_d;
    logic            proto_q, proto_d;

    logic            slot_start;
    logic            idle;
    logic            arb;
    logic            debt_pending;
    logic            wrap;
    logic [2:0]      win;
    logic            unused_phase;

    assign slot_start   = phiL_NCEN & m8c[0];
    assign idle         = (state_q == StIdle);
    assign arb          = slot_start & idle & ~disp_own;
    assign debt_pending = (debt_q != 3'd0);
    assign wrap         = slot_start & (timer_q == TW'(REFRESH_SLOTS - 1));
    assign unused_phase = ^{m8c[7], m8c[3], m8c[1]};

    // Refresh is never deferred by the CPU burst limit; the override only reorders CPU vs CMD.
    always_comb begin
        win = 3'b000;
        if (debt_pending) begin
            win = 3'b001;
        end else if (cpu_req && cmd_req && (streak_q == SW'(CPU_MAXBURST))) begin
            win = 3'b100;
        end else if (cpu_req) begin
            win = 3'b010;
        end else if (cmd_req) begin
            win = 3'b100;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        debt_d    = debt_q;
        streak_d  = streak_q;
        wr_d      = wr_q;
        grant_d   = grant_q;
        cpu_ack_d = cpu_ack_q;
        cmd_ack_d = cmd_ack_q;
        rd_stb_d  = rd_stb_q;
        ras_n_d   = ras_n_q;
        cas_n_d   = cas_n_q;
        we_n_d    = we_n_q;
        col_sel_d = col_sel_q;
        proto_d   = proto_q;

        if (phiL_NCEN) begin
            cpu_ack_d = 1'b0;
            cmd_ack_d = 1'b0;
            rd_stb_d  = 1'b0;

            if (slot_start) begin
                timer_d = wrap ? '0 : timer_q + TW'(1);
            end

            // Simultaneous increment and decrement cancel out.
            if (wrap && !(arb && win[0]) && debt_q != 3'd7) begin
                debt_d = debt_q + 3'd1;
            end else if (!wrap && arb && win[0]) begin
                debt_d = debt_q - 3'd1;
            end

            if (!cmd_req) begin
                streak_d = '0;
            end else if (arb && win[2]) begin
                streak_d = '0;
            end else if (arb && win[1]) begin
                streak_d = streak_q + SW'(1);
            end

            if (slot_start && !idle) begin
                proto_d = 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (arb && win != 3'b000) begin
                        state_d = StRow;
                        grant_d = win;
                        wr_d    = win[1] ? cpu_wr : (win[2] ? cmd_wr : 1'b0);
                        ras_n_d = 1'b0;
                    end
                end
                StRow: begin
                    if (m8c[2]) begin
                        state_d   = StCol;
                        col_sel_d = 1'b1;
                        cas_n_d   = grant_q[0];
                        we_n_d    = grant_q[0] | ~wr_q;
                    end
                end
                StCol: begin
                    if (m8c[4]) begin
                        state_d = StData;
                    end
                end
                StData: begin
                    if (m8c[5]) begin
                        cas_n_d  = 1'b1;
                        we_n_d   = 1'b1;
                        rd_stb_d = ~grant_q[0] & ~wr_q;
                    end
                    if (m8c[6]) begin
                        state_d   = StIdle;
                        grant_d   = 3'b000;
                        ras_n_d   = 1'b1;
                        col_sel_d = 1'b0;
                        cpu_ack_d = grant_q[1];
                        cmd_ack_d = grant_q[2];
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge phiA or posedge RST_async) begin
        if (RST_async) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            debt_q    <= 3'd0;
            streak_q  <= '0;
            wr_q      <= 1'b0;
            grant_q   <= 3'b000;
            cpu_ack_q <= 1'b0;
            cmd_ack_q <= 1'b0;
            rd_stb_q  <= 1'b0;
            ras_n_q   <= 1'b1;
            cas_n_q   <= 1'b1;
            we_n_q    <= 1'b1;
            col_sel_q <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            debt_q    <= debt_d;
            streak_q  <= streak_d;
            wr_q      <= wr_d;
            grant_q   <= grant_d;
            cpu_ack_q <= cpu_ack_d;
            cmd_ack_q <= cmd_ack_d;
            rd_stb_q  <= rd_stb_d;
            ras_n_q   <= ras_n_d;
            cas_n_q   <= cas_n_d;
            we_n_q    <= we_n_d;
            col_sel_q <= col_sel_d;
            proto_q   <= proto_d;
        end
    end

    assign grant     = grant_q;
    assign cpu_ack   = cpu_ack_q;
    assign cmd_ack   = cmd_ack_q;
    assign rd_stb    = rd_stb_q;
    assign ras_n     = ras_n_q;
    assign cas_n     = cas_n_q;
    assign we_n      = we_n_q;
    assign col_sel   = col_sel_q;
    assign proto_err = proto_q;

`ifdef IKA9958_VRAM_SCHED_STATS_EN
    logic [15:0] stat_q;
    logic        contended;

    assign contended = (debt_pending & cpu_req) | (debt_pending & cmd_req) | (cpu_req & cmd_req);

    always_ff @(posedge phiA or posedge RST_async) begin
        if (RST_async) begin
            stat_q <= 16'h0000;
        end else if (slot_start && !disp_own && contended && stat_q != 16'hFFFF) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_contend = stat_q;
`else
    assign stat_contend = 16'h0000;
`endif

endmodule

// File: tb/tb_ika9958_vram_slot_sched.sv
// Self-checking bench for ika9958_vram_slot_sched: directed slot sequence with a reference model
// feeding an expected-access scoreboard.
module tb_ika9958_vram_slot_sched;

    localparam int unsigned RS = 16;
    localparam int unsigned MB = 3;

    logic        phiA = 1'b0;
    logic        RST_async;
    logic        phiL_NCEN;
    logic [7:0]  m8c;
    logic        disp_own;
    logic        cpu_req;
    logic        cpu_wr;
    logic        cmd_req;
    logic        cmd_wr;
    logic [2:0]  grant;
    logic        cpu_ack;
    logic        cmd_ack;
    logic        rd_stb;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic        col_sel;
    logic        proto_err;
    logic [15:0] stat_contend;

    ika9958_vram_slot_sched #(
        .REFRESH_SLOTS(RS),
        .CPU_MAXBURST (MB)
    ) dut (
        .phiA        (phiA),
        .RST_async   (RST_async),
        .phiL_NCEN   (phiL_NCEN),
        .m8c         (m8c),
        .disp_own    (disp_own),
        .cpu_req     (cpu_req),
        .cpu_wr      (cpu_wr),
        .cmd_req     (cmd_req),
        .cmd_wr      (cmd_wr),
        .grant       (grant),
        .cpu_ack     (cpu_ack),
        .cmd_ack     (cmd_ack),
        .rd_stb      (rd_stb),
        .ras_n       (ras_n),
        .cas_n       (cas_n),
        .we_n        (we_n),
        .col_sel     (col_sel),
        .proto_err   (proto_err),
        .stat_contend(stat_contend)
    );

    always #5 phiA = ~phiA;

    typedef struct packed {
        logic [2:0] g;
        logic       wr;
    } acc_t;

    acc_t sb_q[$];
    acc_t cur;
    int   n_pass = 0;
    int   n_fail = 0;
    int   slot_no = 0;
    int   m_timer, m_debt, m_streak, m_stat;
    bit   m_busy, m_proto;
    bit   cpu_keep, cmd_keep;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] obs_view();
        return 16'({grant, cpu_ack, cmd_ack, rd_stb, ras_n, cas_n, we_n, col_sel});
    endfunction

    // Expected outputs visible during phase v of a slot carrying access e (v=8: next slot start).
    function automatic logic [15:0] exp_view(input acc_t e, input int v);
        logic [2:0] g;
        logic acc, mem, e_ras, e_cas, e_we, e_col, e_rd, e_cpu, e_cmd;
        acc   = (e.g != 3'b000);
        mem   = acc & ~e.g[0];
        g     = (v >= 1 && v <= 6) ? e.g : 3'b000;
        e_ras = !(acc && v >= 1 && v <= 6);
        e_col = acc && v >= 3 && v <= 6;
        e_cas = !(mem && v >= 3 && v <= 5);
        e_we  = !(mem && e.wr && v >= 3 && v <= 5);
        e_rd  = mem && !e.wr && v == 6;
        e_cpu = e.g[1] && v == 7;
        e_cmd = e.g[2] && v == 7;
        return 16'({g, e_cpu, e_cmd, e_rd, e_ras, e_cas, e_we, e_col});
    endfunction

    task automatic m_reset();
        m_timer  = 0;
        m_debt   = 0;
        m_streak = 0;
        m_stat   = 0;
        m_busy   = 0;
        m_proto  = 0;
    endtask

    task automatic model_slot(input bit disp, output bit pushed);
        acc_t e;
        bit   arb, wrap;
        int   pend;
        e      = '0;
        arb    = !m_busy && !disp;
        pushed = 0;
        if (arb) begin
            if (m_debt > 0) e.g = 3'b001;
            else if (cpu_req && cmd_req && m_streak == MB) begin e.g = 3'b100; e.wr = cmd_wr; end
            else if (cpu_req) begin e.g = 3'b010; e.wr = cpu_wr; end
            else if (cmd_req) begin e.g = 3'b100; e.wr = cmd_wr; end
        end
        if (!m_busy) begin
            sb_q.push_back(e);
            pushed = 1;
        end
        pend = int'(m_debt > 0) + int'(cpu_req) + int'(cmd_req);
        if (!disp && pend >= 2 && m_stat < 65535) m_stat++;
        if (m_busy) m_proto = 1;
        wrap    = (m_timer == int'(RS) - 1);
        m_timer = wrap ? 0 : m_timer + 1;
        if (wrap && !e.g[0] && m_debt < 7) m_debt++;
        else if (!wrap && e.g[0]) m_debt--;
        if (!cmd_req) m_streak = 0;
        else if (e.g[2]) m_streak = 0;
        else if (e.g[1]) m_streak++;
        if (e.g != 3'b000) m_busy = 1;
    endtask

    task automatic do_reset();
        RST_async = 1'b1;
        phiL_NCEN = 1'b0;
        m8c       = 8'h00;
        repeat (2) @(posedge phiA);
        @(negedge phiA);
        m_reset();
        cur = '0;
        sb_q.delete();
        chk("reset_view", obs_view(), exp_view('0, 0));
        chk("reset_proto", 16'(proto_err), 16'h0000);
        chk("reset_stat", stat_contend, 16'h0000);
        RST_async = 1'b0;
    endtask

    // One 8-phase slot; inj_p ORs a stray slot strobe into that phase, rst_p pulses reset there.
    task automatic run_slot(input bit disp, input int inj_p, input int rst_p, input bit gaps);
        bit pushed;
        for (int p = 0; p < 8; p++) begin
            m8c = 8'(1 << p);
            if (p == inj_p) m8c[0] = 1'b1;
            phiL_NCEN = 1'b1;
            disp_own  = disp;
            pushed    = 0;
            if (p == rst_p) begin
                RST_async = 1'b1;
                #1;
                chk($sformatf("slot%0d_async_rst", slot_no), obs_view(), exp_view('0, 0));
                m_reset();
                cur = '0;
                sb_q.delete();
                @(posedge phiA);
                @(negedge phiA);
                RST_async = 1'b0;
            end else begin
                if (m8c[0]) model_slot(disp, pushed);
                else if (!cmd_req) m_streak = 0;
                @(posedge phiA);
                @(negedge phiA);
                if (pushed) cur = sb_q.pop_front();
                if (p == 6 && cur.g != 3'b000) m_busy = 0;
            end
            chk($sformatf("slot%0d_v%0d", slot_no, p + 1), obs_view(), exp_view(cur, p + 1));
            if (p == 6) begin
                if (cur.g[1] && !cpu_keep) cpu_req = 1'b0;
                if (cur.g[2] && !cmd_keep) cmd_req = 1'b0;
            end
            if (gaps) begin
                phiL_NCEN = 1'b0;
                @(posedge phiA);
                @(negedge phiA);
                chk($sformatf("slot%0d_gap%0d", slot_no, p + 1), obs_view(),
                    exp_view(cur, p + 1));
            end
        end
        chk($sformatf("slot%0d_proto", slot_no), 16'(proto_err), 16'(m_proto));
`ifdef IKA9958_VRAM_SCHED_STATS_EN
        chk($sformatf("slot%0d_stat", slot_no), stat_contend, 16'(m_stat));
`else
        chk($sformatf("slot%0d_stat", slot_no), stat_contend, 16'h0000);
`endif
        slot_no++;
    endtask

    initial begin
        RST_async = 1'b1;
        phiL_NCEN = 1'b0;
        m8c       = 8'h00;
        disp_own  = 1'b0;
        cpu_req   = 1'b0;
        cpu_wr    = 1'b0;
        cmd_req   = 1'b0;
        cmd_wr    = 1'b0;
        cpu_keep  = 0;
        cmd_keep  = 0;
        do_reset();

        // 16 idle slots build one unit of refresh debt; slot 17 pays it (with enable gaps).
        for (int s = 0; s < 16; s++) run_slot(0, -1, -1, 0);
        run_slot(0, -1, -1, 1);

        // CPU read.
        cpu_req = 1'b1;
        cpu_wr  = 1'b0;
        run_slot(0, -1, -1, 0);

        // Sustained contention: CPU,CPU,CPU,CMD,CPU.
        cpu_req  = 1'b1;
        cpu_wr   = 1'b1;
        cmd_req  = 1'b1;
        cmd_wr   = 1'b0;
        cpu_keep = 1;
        cmd_keep = 1;
        for (int s = 0; s < 5; s++) run_slot(0, -1, -1, 0);
        cpu_keep = 0;
        cmd_keep = 0;
        cpu_req  = 1'b0;
        cmd_req  = 1'b0;

        // Display-owned slot defers a pending CPU write by one slot.
        cpu_req = 1'b1;
        cpu_wr  = 1'b1;
        run_slot(1, -1, -1, 0);
        run_slot(0, -1, -1, 0);
        run_slot(0, -1, -1, 0);

        // Stray slot strobe during DATA: sticky error, access still completes.
        cmd_req = 1'b1;
        cmd_wr  = 1'b1;
        run_slot(0, 5, -1, 0);
        run_slot(0, -1, -1, 0);
        do_reset();

        // Reset at phase 4 of a CMD write drops it; it is re-granted next slot.
        cmd_req = 1'b1;
        cmd_wr  = 1'b1;
        run_slot(0, -1, 4, 0);
        run_slot(0, -1, -1, 0);
        run_slot(0, -1, -1, 0);

        // Mixed traffic with display slots and refresh interleaved.
        for (int s = 0; s < 24; s++) begin
            if (!cpu_req && $urandom_range(0, 1) == 1) begin
                cpu_req = 1'b1;
                cpu_wr  = 1'($urandom_range(0, 1));
            end
            if (!cmd_req && $urandom_range(0, 1) == 1) begin
                cmd_req = 1'b1;
                cmd_wr  = 1'($urandom_range(0, 1));
            end
            run_slot($urandom_range(0, 3) == 0, -1, -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
